// File: rtl/stopwatch_pkg.sv
// Shared BCD constants, digit type and load clamp helper
// for the stopwatch BCD counter.
package stopwatch_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    function automatic bcd_digit_t clamp_digit(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_counter_prescaler.sv
// Step prescaler: counts 0..PERIOD-1 while enabled, pauses
// in place when disabled, and flags the terminal count.
module tick_prescaler #(
    parameter int PERIOD = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic sync_clr,
    output logic tick
);

    localparam int CW = $clog2(PERIOD);
    localparam logic [CW-1:0] TC = CW'(PERIOD - 1);

    logic [CW-1:0] r_cnt;
    logic          w_tc;

    assign w_tc = (r_cnt == TC);
    assign tick = enable & w_tc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (sync_clr) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Up/down BCD stopwatch with wrap/saturate limit handling.
// Lap display freeze is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int TICKS_1_SECOND   = 100_000_000,
    parameter int STEPS_PER_SECOND = 10,
    parameter int NUM_DIGITS       = 4,
    parameter int WRAP             = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        start_stop,
    input  logic                        down,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
    input  logic                        lap,
    output logic                        running,
    output logic [BCD_W*NUM_DIGITS-1:0] digits,
    output logic                        step_pulse,
    output logic                        overflow,
    output logic                        lap_active
);

    localparam int PERIOD = TICKS_1_SECOND / STEPS_PER_SECOND;
    localparam int W      = BCD_W * NUM_DIGITS;

    generate
        if (PERIOD < 2 || NUM_DIGITS < 1) begin : g_bad_cfg
            $error("stopwatch_bcd_counter: step period < 2 or NUM_DIGITS < 1");
        end
    endgenerate

    logic         r_running;
    logic [W-1:0] r_live;
    logic [W-1:0] w_next;
    logic [W-1:0] w_load;
    logic         w_limit;
    logic         w_tick;
    logic         w_presc_clr;

    assign w_presc_clr = clear | load;

    tick_prescaler #(
        .PERIOD(PERIOD)
    ) u_presc (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (r_running),
        .sync_clr(w_presc_clr),
        .tick    (w_tick)
    );

    // Ripple carry/borrow; a carry out of the top digit marks the limit.
    always_comb begin
        logic       c;
        bcd_digit_t d;
        c      = 1'b1;
        w_next = r_live;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = r_live[i*BCD_W +: BCD_W];
            if (c) begin
                if (down) begin
                    if (d == '0) begin
                        w_next[i*BCD_W +: BCD_W] = BCD_MAX;
                    end else begin
                        w_next[i*BCD_W +: BCD_W] = d - 1'b1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == BCD_MAX) begin
                        w_next[i*BCD_W +: BCD_W] = '0;
                    end else begin
                        w_next[i*BCD_W +: BCD_W] = d + 1'b1;
                        c = 1'b0;
                    end
                end
            end
        end
        w_limit = c;
    end

    always_comb begin
        w_load = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_load[i*BCD_W +: BCD_W] = clamp_digit(load_value[i*BCD_W +: BCD_W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_running <= 1'b0;
        end else begin
            r_running <= r_running ^ start_stop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= '0;
        end else if (clear) begin
            r_live <= '0;
        end else if (load) begin
            r_live <= w_load;
        end else if (w_tick && (WRAP != 0 || !w_limit)) begin
            r_live <= w_next;
        end
    end

    assign running    = r_running;
    assign step_pulse = w_tick & ~clear;
    assign overflow   = w_tick & ~clear & ~load & w_limit;

`ifdef STOPWATCH_LAP_EN
    logic         r_lap_active;
    logic [W-1:0] r_lap_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lap_active <= 1'b0;
            r_lap_value  <= '0;
        end else if (clear) begin
            r_lap_active <= 1'b0;
        end else if (lap) begin
            if (!r_lap_active) begin
                r_lap_value <= r_live;
            end
            r_lap_active <= ~r_lap_active;
        end
    end

    assign lap_active = r_lap_active;
    assign digits     = r_lap_active ? r_lap_value : r_live;
`else
    logic w_unused_lap;

    assign w_unused_lap = lap;
    assign lap_active   = 1'b0;
    assign digits       = r_live;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench: a wrapping and a saturating instance checked every
// cycle against a decimal-integer stopwatch model plus literal checks.
module tb_stopwatch_bcd_counter;

    localparam int PER  = 10;
    localparam int MAXV = 9999;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        start_stop = 1'b0;
    logic        down = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = '0;
    logic        lap = 1'b0;

    logic        run_w, run_s, sp_w, sp_s, ov_w, ov_s, la_w, la_s;
    logic [15:0] dg_w, dg_s;

    int n_chk = 0;
    int n_fail = 0;
    int n_sp = 0;
    int n_ov_w = 0;
    int n_ov_s = 0;
    bit sp_seen = 1'b0;

    always #5 clk = ~clk;

    stopwatch_bcd_counter #(
        .TICKS_1_SECOND(100), .STEPS_PER_SECOND(10),
        .NUM_DIGITS(4), .WRAP(1)
    ) dut_w (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .start_stop(start_stop), .down(down), .load(load),
        .load_value(load_value), .lap(lap), .running(run_w),
        .digits(dg_w), .step_pulse(sp_w), .overflow(ov_w),
        .lap_active(la_w)
    );

    stopwatch_bcd_counter #(
        .TICKS_1_SECOND(100), .STEPS_PER_SECOND(10),
        .NUM_DIGITS(4), .WRAP(0)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .start_stop(start_stop), .down(down), .load(load),
        .load_value(load_value), .lap(lap), .running(run_s),
        .digits(dg_s), .step_pulse(sp_s), .overflow(ov_s),
        .lap_active(la_s)
    );

    // Model state; index 0 = wrapping instance, 1 = saturating.
    bit m_run = 1'b0;
    bit m_lapa = 1'b0;
    int m_presc = 0;
    int m_live [2] = '{0, 0};
    int m_lapv [2] = '{0, 0};

    wire m_tick = m_run && (m_presc == PER - 1);

    function automatic int step_val(input int v, input bit dn, input bit wrap);
        if (dn) return (v == 0) ? (wrap ? MAXV : 0) : v - 1;
        return (v == MAXV) ? (wrap ? 0 : MAXV) : v + 1;
    endfunction

    function automatic int clampv(input logic [15:0] x);
        int v = 0;
        int mul = 1;
        int n;
        for (int i = 0; i < 4; i++) begin
            n = int'(x[i*4 +: 4]);
            if (n > 9) n = 9;
            v += n * mul;
            mul *= 10;
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run   <= 1'b0;
            m_presc <= 0;
            m_lapa  <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_live[k] <= 0;
                m_lapv[k] <= 0;
            end
        end else begin
`ifdef STOPWATCH_LAP_EN
            if (clear) begin
                m_lapa <= 1'b0;
            end else if (lap) begin
                if (!m_lapa) begin
                    for (int k = 0; k < 2; k++) m_lapv[k] <= m_live[k];
                end
                m_lapa <= !m_lapa;
            end
`endif
            if (clear) begin
                m_presc <= 0;
                for (int k = 0; k < 2; k++) m_live[k] <= 0;
            end else if (load) begin
                m_presc <= 0;
                for (int k = 0; k < 2; k++) m_live[k] <= clampv(load_value);
            end else begin
                if (m_run) m_presc <= (m_presc + 1) % PER;
                if (m_tick) begin
                    for (int k = 0; k < 2; k++)
                        m_live[k] <= step_val(m_live[k], down, k == 0);
                end
            end
            m_run <= m_run ^ start_stop;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic compare_all();
        bit          e_sp, e_step, e_ov;
        logic [15:0] e_dg;
        e_sp   = m_tick && !clear;
        e_step = e_sp && !load;
        for (int k = 0; k < 2; k++) begin
            e_ov = e_step && (down ? (m_live[k] == 0) : (m_live[k] == MAXV));
            e_dg = to_bcd(m_lapa ? m_lapv[k] : m_live[k]);
            chk($sformatf("running[%0d]", k), k == 0 ? run_w : run_s, m_run);
            chk($sformatf("digits[%0d]", k), k == 0 ? dg_w : dg_s, e_dg);
            chk($sformatf("step_pulse[%0d]", k), k == 0 ? sp_w : sp_s, e_sp);
            chk($sformatf("overflow[%0d]", k), k == 0 ? ov_w : ov_s, e_ov);
            chk($sformatf("lap_active[%0d]", k), k == 0 ? la_w : la_s, m_lapa);
        end
        sp_seen = sp_w;
        if (sp_w) n_sp++;
        if (ov_w) n_ov_w++;
        if (ov_s) n_ov_s++;
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compare_all();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start_stop = 1'b1;
        cyc();
        start_stop = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        load_value = v;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        int n;
        cyc(2);
        chk("reset_digits", dg_w, 16'h0000);
        chk("reset_running", run_w, 1'b0);
        rst_n = 1'b1;

        // Basic count: 35 running cycles -> three steps.
        pulse_start();
        n_sp = 0;
        cyc(35);
        chk("basic_digits_w", dg_w, 16'h0003);
        chk("basic_digits_s", dg_s, 16'h0003);
        chk("basic_steps", n_sp, 3);

        // Up at the limit: wrap vs saturate.
        do_load(16'h9999);
        n_ov_w = 0;
        n_ov_s = 0;
        cyc(10);
        chk("wrap_digits_w", dg_w, 16'h0000);
        chk("sat_digits_s", dg_s, 16'h9999);
        chk("wrap_ovf_w", n_ov_w, 1);
        chk("sat_ovf_s", n_ov_s, 1);

        // Down count through zero.
        down = 1'b1;
        do_load(16'h0002);
        n_ov_w = 0;
        n_ov_s = 0;
        cyc(10);
        chk("down1_w", dg_w, 16'h0001);
        cyc(10);
        chk("down0_w", dg_w, 16'h0000);
        cyc(10);
        chk("down_wrap_w", dg_w, 16'h9999);
        chk("down_sat_s", dg_s, 16'h0000);
        chk("down_ovf_w", n_ov_w, 1);
        chk("down_ovf_s", n_ov_s, 1);
        down = 1'b0;

        // Pause with prescaler at 6, resume finishes the period.
        cyc(5);
        pulse_start();
        cyc(50);
        chk("pause_digits_w", dg_w, 16'h9999);
        chk("pause_running", run_w, 1'b0);
        pulse_start();
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (sp_seen) begin
                n = i;
                break;
            end
        end
        chk("resume_latency", n, 4);

        // Clear + load + step on one edge; then a clamped load.
        cyc(9);
        clear = 1'b1;
        load = 1'b1;
        load_value = 16'h4321;
        cyc();
        clear = 1'b0;
        load = 1'b0;
        chk("clr_no_step", sp_seen, 1'b0);
        chk("clr_digits_w", dg_w, 16'h0000);
        do_load(16'h12F4);
        chk("clamp_w", dg_w, 16'h1294);
        chk("clamp_s", dg_s, 16'h1294);

        // Lap freeze while the live value keeps counting.
        do_load(16'h0005);
        lap = 1'b1;
        cyc();
        lap = 1'b0;
        cyc(30);
`ifdef STOPWATCH_LAP_EN
        chk("lap_frozen_w", dg_w, 16'h0005);
        chk("lap_active_w", la_w, 1'b1);
`else
        chk("lap_ignored_w", dg_w, 16'h0008);
        chk("lap_tied_w", la_w, 1'b0);
`endif
        lap = 1'b1;
        cyc();
        lap = 1'b0;
        chk("lap_release_w", dg_w, 16'h0008);
        chk("lap_release_s", dg_s, 16'h0008);
        chk("lap_off_w", la_w, 1'b0);

        // Asynchronous reset mid-period.
        cyc(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_digits_w", dg_w, 16'h0000);
        chk("arst_digits_s", dg_s, 16'h0000);
        chk("arst_running", run_w, 1'b0);
        chk("arst_step", sp_w, 1'b0);
        chk("arst_ovf", ov_w, 1'b0);
        chk("arst_lap", la_w, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        cyc(15);
        chk("post_rst_digits", dg_w, 16'h0000);
        chk("post_rst_running", run_w, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd_counter.md
STOPWATCH_BCD_COUNTER -- requirements
Module: stopwatch_bcd_counter

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- TICKS_1_SECOND, 100_000_000, clk cycles per second.
- STEPS_PER_SECOND, 10, count steps per second.
- NUM_DIGITS, 4, BCD digit count.
- WRAP, 1, 1 = wrap at limit, 0 = saturate.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, reset; one clock, reset asynchronous and active-low.
- clear, in, 1, synchronous zero.
- start_stop, in, 1, single-cycle pulse that toggles run.
- down, in, 1, 1 = count down.
- load, in, 1, pulse that loads load_value.
- load_value, in, 4*NUM_DIGITS, BCD preset.
- lap, in, 1, lap toggle pulse.
- running, out, 1, run state.
- digits, out, 4*NUM_DIGITS, displayed BCD value; digit 0 = LSB nibble.
- step_pulse, out, 1, one cycle per count step.
- overflow, out, 1, one-cycle pulse at limit.
- lap_active, out, 1, display frozen.

Function
REQ-003 SHALL run a prescaler counting 0..TICKS_1_SECOND/STEPS_PER_SECOND-1 only while running=1.
- Prescaler width: $clog2 of the period.
REQ-004 SHALL assert step_pulse for exactly one cycle when the prescaler is at terminal count and running=1, returning the prescaler to 0.
- The BCD value updates on that same edge.
REQ-005 SHALL increment the BCD value (down=0) or decrement it (down=1) by one per step.
- Each digit wraps 9->0 (up) or 0->9 (down) with a carry/borrow into the next digit.
REQ-006 SHALL handle the count limit as follows:
- Up at all-9s: WRAP=1 goes to all-0s; WRAP=0 holds at all-9s.
- Down at all-0s: WRAP=1 goes to all-9s; WRAP=0 holds at all-0s.
- overflow pulses for one cycle on the step that reaches the limit, in both WRAP modes.
REQ-007 SHALL toggle running on each start_stop pulse.
- Stopping pauses the prescaler at its current value; resuming continues the partial period.
REQ-008 SHALL, on clear, zero the BCD value and prescaler, release the lap, and suppress that cycle's step_pulse and overflow.
- running is unaffected by clear.
REQ-009 SHALL, on load, copy load_value into the BCD value and zero the prescaler.
- Any load nibble >9 is clamped to 9.
- running is unaffected by load.
REQ-010 SHALL resolve simultaneous events by priority clear > load > step.
- start_stop is evaluated independently, so clear with start_stop clears and toggles.
REQ-011 SHALL sample down at each step; a direction change mid-period takes effect at the next step.
REQ-012 SHALL count the live value continuously regardless of lap state.
REQ-013 SHALL reject, at elaboration, configurations where TICKS_1_SECOND/STEPS_PER_SECOND < 2 or NUM_DIGITS < 1.

Reset
REQ-014 SHALL, while rst_n=0, asynchronously set all of the following to 0:
- running, digits, step_pulse, overflow, lap_active, prescaler, lap register.
REQ-015 SHALL abort any partial period on reset, with counting resuming only after a start_stop pulse.

Configuration
REQ-016 SHALL implement the lap feature only when STOPWATCH_LAP_EN is defined:
- A lap pulse with lap_active=0 captures the live value into a lap register and sets lap_active.
- While lap_active=1, digits shows the lap register.
- The next lap pulse clears lap_active and digits shows the live value again.
REQ-017 SHALL, without STOPWATCH_LAP_EN:
- ignore lap;
- tie lap_active to 0;
- drive digits from the live value;
- include no lap register.

Structure
REQ-018 SHALL place the following in the shared package stopwatch_pkg:
- BCD digit width constant (4);
- the BCD max-digit constant (9);
- a bcd_digit_t typedef.
REQ-019 SHALL implement the prescaler as sub-module tick_prescaler, with inputs clk, rst_n, enable, sync_clr and output tick.

Verification
REQ-020 SHALL be verified with TICKS_1_SECOND=100, STEPS_PER_SECOND=10, NUM_DIGITS=4, i.e. a 10-cycle step, covering these scenarios:
- Basic count: start_stop, run 35 cycles -> digits=0003, step_pulse every 10th cycle.
- Wrap and saturate: load 9999, up -> WRAP=1 gives 0000 with overflow pulse; WRAP=0 holds 9999 with one overflow pulse.
- Down count: load 0002, down=1, 3 steps -> 0001, 0000, then 9999 (WRAP=1) with overflow.
- Pause and resume: pause at prescaler 6, wait 50 cycles -> digits unchanged; resume -> next step_pulse after 4 cycles.
- Simultaneous clear, load and step on one edge -> digits=0000, no step_pulse. Load 12F4 -> digits=1294.
- Lap (with STOPWATCH_LAP_EN): lap at 0005 -> digits frozen at 0005 while live counts. Second lap -> live value shown. Assert rst_n=0 mid-period -> all outputs 0 immediately.
